// File: rtl/accum_warp_looper_arbiter_if.sv
// Handshake bundle between the config-stream requesters, the warp-looper arbiter
// and the downstream consumer; the arbiter takes the slave view.
package TauCfg;
    localparam int N_ICFG         = 3;
    localparam int GLOBAL_ADDR_BW = 32;
endpackage

interface accum_warp_looper_arbiter_if #(
    parameter int N_CFG = TauCfg::N_ICFG,
    parameter int ABW   = TauCfg::GLOBAL_ADDR_BW
);
    localparam int NCFG_BW = $clog2(N_CFG + 1);

    logic                          start_dval;
    logic [N_CFG-1:0]              req_rdy;
    logic [N_CFG-1:0]              req_ack;
    logic [N_CFG-1:0][ABW-1:0]     i_linear;
    logic [N_CFG-1:0]              i_retire;
    logic [N_CFG-1:0]              i_islast;

    logic                          dst_rdy;
    logic                          dst_ack;
    logic [NCFG_BW-1:0]            o_id;
    logic [ABW-1:0]                o_linear;
    logic                          o_retire;
    logic                          o_islast;

    logic                          fin_dval;
    logic [NCFG_BW-1:0]            o_fin_id;
    logic                          o_done;

    modport slave (
        input  start_dval, req_rdy, i_linear, i_retire, i_islast, dst_ack,
        output req_ack, dst_rdy, o_id, o_linear, o_retire, o_islast,
        output fin_dval, o_fin_id, o_done
    );

    modport master (
        output start_dval, req_rdy, i_linear, i_retire, i_islast, dst_ack,
        input  req_ack, dst_rdy, o_id, o_linear, o_retire, o_islast,
        input  fin_dval, o_fin_id, o_done
    );
endinterface

// File: rtl/accum_warp_looper_arbiter.sv
// Round-robin arbiter that funnels per-config warp requests into a single
// registered output slot, tracking which configs have delivered their last warp.
module accum_warp_looper_arbiter #(
    parameter int N_CFG = TauCfg::N_ICFG,
    parameter int ABW   = TauCfg::GLOBAL_ADDR_BW
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    accum_warp_looper_arbiter_if.slave        bus
);
    localparam int                 NCFG_BW   = $clog2(N_CFG + 1);
    localparam logic [NCFG_BW-1:0] PTR_RESET = NCFG_BW'(N_CFG - 1);
    localparam logic [NCFG_BW:0]   N_WIDE    = (NCFG_BW + 1)'(N_CFG);

    logic [N_CFG-1:0]   finished;
    logic [N_CFG-1:0]   finished_nxt;
    logic [N_CFG-1:0]   pending_last;
    logic [N_CFG-1:0]   pending_nxt;
    logic [N_CFG-1:0]   eligible;
    logic [NCFG_BW-1:0] ptr;
    logic [NCFG_BW-1:0] winner;
    logic [NCFG_BW:0]   idx;
    logic               any_elig;
    logic               armed;
    logic               slot_load;
    logic               grant;
    logic               fin;

    logic               dst_rdy_q;
    logic [NCFG_BW-1:0] id_q;
    logic [ABW-1:0]     linear_q;
    logic               retire_q;
    logic               islast_q;

    // An id with its last beat still sitting in the slot must not win again.
    assign eligible  = bus.req_rdy & ~finished & ~pending_last;
    assign slot_load = !dst_rdy_q || bus.dst_ack;
    assign grant     = armed && slot_load && any_elig;
    assign fin       = bus.dst_ack && dst_rdy_q && islast_q;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner   = '0;
        any_elig = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N_CFG; k++) begin
            idx = {1'b0, ptr} + (NCFG_BW + 1)'(k);
            if (idx >= N_WIDE) begin
                idx = idx - N_WIDE;
            end
            if (!any_elig && eligible[idx[NCFG_BW-1:0]]) begin
                any_elig = 1'b1;
                winner   = idx[NCFG_BW-1:0];
            end
        end
    end

    always_comb begin
        bus.req_ack = '0;
        if (grant) begin
            bus.req_ack[winner] = 1'b1;
        end
    end

    // A new pass wipes both masks, but a last beat still waiting in the slot keeps its block.
    always_comb begin
        finished_nxt = finished;
        pending_nxt  = pending_last;
        if (fin) begin
            finished_nxt[id_q] = 1'b1;
            pending_nxt[id_q]  = 1'b0;
        end
        if (bus.start_dval) begin
            finished_nxt = '0;
            pending_nxt  = '0;
            if (dst_rdy_q && islast_q && !bus.dst_ack) begin
                pending_nxt[id_q] = 1'b1;
            end
        end
        if (grant && bus.i_islast[winner]) begin
            pending_nxt[winner] = 1'b1;
        end
    end

    // Holds off arbitration for the first cycle after reset release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            finished     <= '0;
            pending_last <= '0;
            ptr          <= PTR_RESET;
        end else begin
            finished     <= finished_nxt;
            pending_last <= pending_nxt;
            if (bus.start_dval) begin
                ptr <= PTR_RESET;
            end else if (grant) begin
                ptr <= winner;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dst_rdy_q <= 1'b0;
            id_q      <= '0;
            linear_q  <= '0;
            retire_q  <= 1'b0;
            islast_q  <= 1'b0;
        end else if (grant) begin
            dst_rdy_q <= 1'b1;
            id_q      <= winner;
            linear_q  <= bus.i_linear[winner];
            retire_q  <= bus.i_retire[winner];
            islast_q  <= bus.i_islast[winner];
        end else if (bus.dst_ack) begin
            dst_rdy_q <= 1'b0;
        end
    end

    assign bus.dst_rdy  = dst_rdy_q;
    assign bus.o_id     = id_q;
    assign bus.o_linear = linear_q;
    assign bus.o_retire = retire_q;
    assign bus.o_islast = islast_q;
    assign bus.fin_dval = fin;
    assign bus.o_fin_id = id_q;
    assign bus.o_done   = &finished;
endmodule

// File: tb/tb_accum_warp_looper_arbiter.sv
// Directed bench for the warp-looper arbiter: expected beats are queued at grant
// time and compared against the output slot when the consumer takes them.
module tb_accum_warp_looper_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;

    typedef struct packed {
        logic [1:0]    id;
        logic [AW-1:0] linear;
        logic          retire;
        logic          islast;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accum_warp_looper_arbiter_if #(.N_CFG(N), .ABW(AW)) bus ();

    accum_warp_looper_arbiter #(.N_CFG(N), .ABW(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    seq   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs(input logic [2:0] rdy, input logic [2:0] last,
                                input logic ack, input logic start);
        bus.req_rdy    = rdy;
        bus.i_islast   = last;
        bus.dst_ack    = ack;
        bus.start_dval = start;
        for (int i = 0; i < N; i++) begin
            bus.i_linear[i] = 32'hA000_0000 + AW'(seq * 16 + i);
            bus.i_retire[i] = ((seq + i) % 2) == 1;
        end
    endtask

    // One clock of stimulus: drive just after the edge, check mid-cycle.
    task automatic step(input logic [2:0] rdy, input logic [2:0] last, input logic ack,
                        input logic start, input logic [2:0] exp_ack, input logic exp_done,
                        input string tag);
        beat_t b;
        logic  full;
        @(posedge clk);
        #1;
        drive_inputs(rdy, last, ack, start);
        #1;
        full = (sb.size() != 0);
        check({tag, ".dst_rdy"}, 64'(bus.dst_rdy), 64'(full));
        if (full) begin
            check({tag, ".o_id"}, 64'(bus.o_id), 64'(sb[0].id));
            check({tag, ".o_linear"}, 64'(bus.o_linear), 64'(sb[0].linear));
        end
        check({tag, ".fin_dval"}, 64'(bus.fin_dval), 64'(ack && full && sb[0].islast));
        check({tag, ".req_ack"}, 64'(bus.req_ack), 64'(exp_ack));
        check({tag, ".o_done"}, 64'(bus.o_done), 64'(exp_done));
        if (ack) begin
            if (!full) begin
                total++;
                bad++;
                $error("FAIL %s.consume observed=empty_scoreboard expected=beat", tag);
            end else begin
                b = sb.pop_front();
                check({tag, ".o_retire"}, 64'(bus.o_retire), 64'(b.retire));
                check({tag, ".o_islast"}, 64'(bus.o_islast), 64'(b.islast));
                if (b.islast) begin
                    check({tag, ".o_fin_id"}, 64'(bus.o_fin_id), 64'(b.id));
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (exp_ack[i]) begin
                b.id     = 2'(i);
                b.linear = 32'hA000_0000 + AW'(seq * 16 + i);
                b.retire = ((seq + i) % 2) == 1;
                b.islast = last[i];
                sb.push_back(b);
            end
        end
        seq++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".dst_rdy"}, 64'(bus.dst_rdy), 64'(0));
        check({tag, ".o_id"}, 64'(bus.o_id), 64'(0));
        check({tag, ".o_linear"}, 64'(bus.o_linear), 64'(0));
        check({tag, ".o_retire"}, 64'(bus.o_retire), 64'(0));
        check({tag, ".o_islast"}, 64'(bus.o_islast), 64'(0));
        check({tag, ".req_ack"}, 64'(bus.req_ack), 64'(0));
        check({tag, ".fin_dval"}, 64'(bus.fin_dval), 64'(0));
        check({tag, ".o_done"}, 64'(bus.o_done), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        drive_inputs(3'b000, 3'b000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive_inputs(3'b111, 3'b000, 1'b0, 1'b0);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("rst_release.req_ack", 64'(bus.req_ack), 64'(0));

        // Full-rate rotation 0,1,2,0
        step(3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, "rr0");
        step(3'b111, 3'b000, 1'b1, 1'b0, 3'b010, 1'b0, "rr1");
        step(3'b111, 3'b000, 1'b1, 1'b0, 3'b100, 1'b0, "rr2");
        step(3'b111, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0, "rr3");
        step(3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, "rr_drain");

        // Backpressure: slot held with id 2 only requesting
        step(3'b100, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, "hold_load");
        step(3'b100, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, "hold1");
        step(3'b100, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, "hold2");
        step(3'b100, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, "hold3");
        step(3'b100, 3'b000, 1'b1, 1'b0, 3'b100, 1'b0, "hold_release");
        step(3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, "hold_drain");

        // id 1 finishes and is locked out
        step(3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, "fin1_load");
        step(3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0, "fin1_consume");
        step(3'b111, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, "fin1_skip_a");
        step(3'b111, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0, "fin1_skip_b");
        step(3'b111, 3'b000, 1'b1, 1'b0, 3'b100, 1'b0, "fin1_skip_c");
        step(3'b010, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, "fin1_locked_a");
        step(3'b010, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, "fin1_locked_b");

        // Remaining ids finish, done rises, new pass restarts at id 0
        step(3'b101, 3'b101, 1'b0, 1'b0, 3'b001, 1'b0, "done_a");
        step(3'b101, 3'b101, 1'b1, 1'b0, 3'b100, 1'b0, "done_b");
        step(3'b101, 3'b101, 1'b1, 1'b0, 3'b000, 1'b0, "done_c");
        step(3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, "done_set");
        step(3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 1'b1, "done_start");
        step(3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, "pass2_first");
        step(3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, "pass2_drain");

        // start coincident with fin of id 2; start also resets the pointer
        step(3'b100, 3'b100, 1'b0, 1'b0, 3'b100, 1'b0, "sf_load");
        step(3'b100, 3'b100, 1'b1, 1'b1, 3'b000, 1'b0, "sf_collide");
        step(3'b100, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, "sf_reelig");
        step(3'b111, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0, "sf_next");
        step(3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, "ptr_start");
        step(3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, "ptr_id0");
        step(3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, "ptr_drain");

        // Reset while a beat is resident
        step(3'b010, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0, "mid_load");
        #1;
        drive_inputs(3'b111, 3'b000, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        sb.delete();
        @(posedge clk);
        #1;
        check("mid_reset_hold.req_ack", 64'(bus.req_ack), 64'(0));
        rst = 1'b0;
        #1;
        check("mid_release.req_ack", 64'(bus.req_ack), 64'(0));
        step(3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, "post_reset");
        step(3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, "post_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
